// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : Buffered UART transmitter. Bytes are queued in a small FIFO
//               and sent as 1 start bit, 8 data bits MSB-first, an optional
//               even-parity bit and STOP_BITS stop bits. Frames leave
//               back-to-back while the FIFO holds data.
// Ports       : sys_clk    - single clock
//               rst_b      - asynchronous active-low reset
//               tx_data    - byte to queue
//               tx_valid   - tx_data valid this cycle
//               tx_ready   - FIFO can accept a byte (not full)
//               uart_tx    - serial line, idles high
//               tx_busy    - a frame is on the line
//               tx_done    - one-cycle pulse in the last stop-bit cycle
//               fifo_level - bytes queued, excluding the frame in flight
// Options     : define UART_TX_PARITY_EN to insert an even-parity bit
//               between D0 and the stop bit(s).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 40,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_AW      = 4
) (
    input  logic             sys_clk,
    input  logic             rst_b,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [FIFO_AW:0] fifo_level
);

    localparam int                 c_DEPTH     = 1 << FIFO_AW;
    localparam int                 c_TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0]    c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0]    c_BIT_PRE   = c_TW'(CLKS_PER_BIT - 2);
    localparam logic [c_TW-1:0]    c_TMR_ONE   = c_TW'(1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0]   c_LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_ready;
    logic [FIFO_AW:0]   w_level_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [7:0]         w_head;

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_TW-1:0]    r_timer;
    logic [2:0]         r_bit_idx;
    logic               r_stop_cnt;
    logic [7:0]         r_shift;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic               w_bit_end;
    logic               w_stop_end;

    // The push is gated by the registered ready, so a full FIFO refuses a
    // byte even in a cycle where a pop frees a slot.
    assign w_push     = tx_valid & r_ready;
    assign w_nonempty = (r_level != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_bit_end  = (r_timer == c_BIT_LAST);
    assign w_stop_end = w_bit_end && (r_stop_cnt == c_STOP_LAST);

    // Pop from IDLE, or from the last stop cycle so the next start bit
    // follows the stop bit with no idle gap.
    assign w_pop = w_nonempty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_level <= w_level_nxt;
            // The level MSB is set only when all entries are occupied.
            r_ready <= ~w_level_nxt[FIFO_AW];
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    // ------------------------------------------------------------------
    // Frame FSM. uart_tx is registered, so each transition loads the line
    // level for the state being entered.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[7];
                        r_shift   <= {r_shift[6:0], 1'b0};
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state    <= S_STOP;
                            r_stop_cnt <= 1'b0;
                            r_tx       <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_timer    <= '0;
                        r_state    <= S_STOP;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end
`endif

                S_STOP: begin
                    // Raise done one edge early so it covers the final cycle.
                    r_done <= (r_timer == c_BIT_PRE) && (r_stop_cnt == c_STOP_LAST);
                    if (w_stop_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_bit_end) begin
                        r_timer    <= '0;
                        r_stop_cnt <= ~r_stop_cnt;
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = r_ready;
    assign uart_tx    = r_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_uart_byte_tx
// Description : Self-checking bench for uart_byte_tx. A frame-schedule model
//               (byte queue plus frame start times) predicts every output on
//               every cycle; a mid-bit sampling receiver decodes the line
//               during the random phase. Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

    localparam int CPB   = 16;
    localparam int STOPB = 1;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (9 + STOPB + PAR) * CPB;

    logic        sys_clk = 1'b0;
    logic        rst_b   = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;
    logic [AW:0] fifo_level;

    always #5 sys_clk = ~sys_clk;

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOPB),
        .FIFO_AW      (AW)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_b      (rst_b),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_busy = 0;
    int n_rx   = 0;
    int n_acc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes waiting, and the start edge of the frame on
    // the line. A frame occupies FRAME cycles from its start edge; the next
    // one may start FRAME edges later, or one edge after a push if idle.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic [7:0] rx_exp[$];
    logic [7:0] cur_b     = 8'h00;
    longint     e         = 0;
    longint     cur_s     = -1;
    longint     next_free = 0;
    bit         rx_en     = 1'b0;

    task automatic model_edge(input logic v, input logic [7:0] d);
        bit do_push;
        do_push = v && (mq.size() < DEPTH);
        if (mq.size() > 0 && e >= next_free) begin
            cur_b     = mq.pop_front();
            cur_s     = e;
            next_free = e + FRAME;
            if (rx_en) rx_exp.push_back(cur_b);
        end
        if (do_push) begin
            mq.push_back(d);
            n_acc++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur_s     = -1;
        next_free = 0;
    endtask

    // {uart_tx, tx_busy, tx_done, tx_ready, fifo_level}
    function automatic logic [8:0] exp_outs();
        logic   act;
        logic   line;
        longint off;
        int     bp;
        act  = (cur_s >= 0) && (e < cur_s + FRAME);
        off  = e - cur_s;
        bp   = int'(off / CPB);
        if (!act)                     line = 1'b1;
        else if (bp == 0)             line = 1'b0;
        else if (bp <= 8)             line = cur_b[8 - bp];
        else if (PAR == 1 && bp == 9) line = ^cur_b;
        else                          line = 1'b1;
        return {line, act, act && (off == FRAME - 1),
                (mq.size() < DEPTH), 5'(mq.size())};
    endfunction

    task automatic tick(input logic v, input logic [7:0] d);
        tx_valid = v;
        tx_data  = d;
        @(posedge sys_clk);
        e++;
        if (rst_b) model_edge(v, d);
        else       model_reset();
        @(negedge sys_clk);
        check("outs", {uart_tx, tx_busy, tx_done, tx_ready, fifo_level}, 32'(exp_outs()));
        if (tx_done) n_done++;
        if (tx_busy) n_busy++;
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((mq.size() > 0 || e < next_free) && g < 60000) begin
            tick(1'b0, 8'h00);
            g++;
        end
        repeat (4) tick(1'b0, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // Mid-bit sampling receiver, active during the random phase.
    // ------------------------------------------------------------------
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (rx_en && rst_b && prev && !uart_tx) begin
                repeat (CPB / 2) @(negedge sys_clk);
                check("rx_start", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sys_clk);
                    b = {b[6:0], uart_tx};
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge sys_clk);
                check("rx_parity", uart_tx, 32'(^b));
`endif
                repeat (CPB) @(negedge sys_clk);
                check("rx_stop", uart_tx, 1);
                if (rx_exp.size() == 0) check("rx_extra_byte", b, 32'h100);
                else                    check("rx_byte", b, 32'(rx_exp.pop_front()));
                n_rx++;
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc0;
        int g;
        int done0;
        int busy0;
        int pm;

        // Reset held for 3 cycles, then a long idle stretch.
        repeat (3) tick(1'b0, 8'h00);
        check("rst_line",  uart_tx, 1);
        check("rst_busy",  tx_busy, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_level", fifo_level, 0);
        rst_b = 1'b1;
        repeat (1000) tick(1'b0, 8'h00);
        check("idle_line",  uart_tx, 1);
        check("idle_level", fifo_level, 0);

        // 0xA5 goes on the line, then 0x00..0x0F fill the FIFO behind it.
        done0 = n_done;
        tick(1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i));
        check("full_level", fifo_level, 16);
        check("full_ready", tx_ready, 0);
        repeat (5) tick(1'b1, 8'hFF);
        check("drop_level", fifo_level, 16);
        drain();
        check("burst_done_count", n_done - done0, 17);

        // Single-frame length, and the parity bit when compiled in.
        busy0 = n_busy;
        tick(1'b1, 8'h07);
        tick(1'b0, 8'h00);
        repeat (9 * CPB + CPB / 2) tick(1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
        check("parity_07", uart_tx, 1);
`endif
        drain();
        check("frame_len", n_busy - busy0, FRAME);
`ifdef UART_TX_PARITY_EN
        tick(1'b1, 8'h03);
        tick(1'b0, 8'h00);
        repeat (9 * CPB + CPB / 2) tick(1'b0, 8'h00);
        check("parity_03", uart_tx, 0);
        drain();
`endif

        // 200 random bytes: a dense burst phase that keeps the FIFO full,
        // then a sparse phase that lets the line go idle between bytes.
        rx_en = 1'b1;
        n_rx  = 0;
        acc0  = n_acc;
        g     = 0;
        while (n_acc - acc0 < 200 && g < 60000) begin
            pm = (n_acc - acc0 < 100) ? 400 : 6;
            tick(($urandom_range(0, 999) < pm), 8'($urandom));
            g++;
        end
        drain();
        rx_en = 1'b0;
        check("rand_accepted", n_acc - acc0, 200);
        check("rx_count", n_rx, 200);
        check("rx_leftover", rx_exp.size(), 0);

        // Asynchronous reset in the middle of the data bits of 0x3C.
        tick(1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
        repeat (3 * CPB) tick(1'b0, 8'h00);
        check("pre_rst_busy",  tx_busy, 1);
        check("pre_rst_level", fifo_level, 5);
        done0 = n_done;
        #2 rst_b = 1'b0;
        #1;
        check("arst_line",  uart_tx, 1);
        check("arst_busy",  tx_busy, 0);
        check("arst_level", fifo_level, 0);
        check("arst_ready", tx_ready, 1);
        @(negedge sys_clk);
        repeat (3) tick(1'b0, 8'h00);
        rst_b = 1'b1;
        repeat (2 * FRAME) tick(1'b0, 8'h00);
        check("arst_no_done", n_done - done0, 0);
        check("arst_idle_line", uart_tx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_byte_tx.md
# uart_byte_tx

Buffered UART transmitter that returns processed image bytes to the host over `uart_tx`. It is the transmit counterpart of the UART byte receiver that loads pixel data from the host, and it uses the same frame format: one start bit, 8 data bits MSB-first, then stop. A 16-entry FIFO decouples the pixel/readback logic from the serial line, so the `top` level can push bytes in bursts while frames go out back-to-back.

## Interface
- `CLKS_PER_BIT`, 40, number of `sys_clk` cycles per serial bit. Minimum 2.
- `STOP_BITS`, 1, stop bits per frame. Legal values are 1 and 2.
- `FIFO_AW`, 4, FIFO address width. Depth is 2^FIFO_AW.
- `sys_clk` in 1: the single clock.
- `rst_b` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid this cycle.
- `tx_ready` out 1: FIFO can accept a byte. Equals `!fifo_full`.
- `uart_tx` out 1: serial line, idles high.
- `tx_busy` out 1: high while a frame is on the line.
- `tx_done` out 1: one-cycle pulse at the end of each frame.
- `fifo_level` out FIFO_AW+1: number of bytes queued, excluding the frame currently in flight.

## Operation
- Push rule: a byte is written on every rising edge where `tx_valid && tx_ready`.
- Pushes while `tx_ready` is low are dropped silently. `fifo_level` does not change.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `uart_tx` = 1.
  - If `fifo_level` != 0, pop the head into an 8-bit shift register and go to START.
- START: `uart_tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Drive `shift[7]`, then shift left. Each bit is held CLKS_PER_BIT cycles.
  - A 3-bit bit index counts 0..7.
  - After bit 7, go to PARITY if it is compiled in, otherwise go to STOP.
- PARITY: `uart_tx` = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- STOP:
  - `uart_tx` = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - In the last cycle of STOP, assert `tx_done`.
  - If the FIFO is non-empty in that same cycle, pop and go straight to START, so there is no idle gap between frames.
  - Otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT).
- `tx_busy` = 1 in every state except IDLE.
- Simultaneous push and pop:
  - Pointers both advance.
  - `fifo_level` is unchanged.
  - When the FIFO is full, `tx_ready` = 0 blocks the push even if a pop happens in the same cycle. The FIFO accepts again on the next cycle.
- Wrap-around: read and write pointers wrap modulo 2^FIFO_AW. Full/empty is decided by the extra MSB of `fifo_level`.
- Reset mid-frame:
  - The frame is aborted, `uart_tx` returns high immediately, and the FIFO is flushed.
  - No `tx_done` is issued.

## Timing
- Reset values:
  - `uart_tx` = 1, `tx_busy` = 0, `tx_done` = 0.
  - `fifo_level` = 0, `tx_ready` = 1.
  - FSM in IDLE, timer 0.
- All outputs are registered. `uart_tx` is driven from a flop, so it is glitch-free.
- Latency with an empty FIFO in IDLE:
  - Byte written on edge k.
  - `uart_tx` falls after edge k+1, and `tx_busy` rises on the same edge.
- Frame length is (9 + STOP_BITS) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled. Defaults give 400 cycles, i.e. 80 ns at the 0.2 ns `sys_clk` period.
- `tx_done` is high for exactly the last cycle of STOP.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and one even-parity bit is inserted between D0 and stop.
  - Frame grows by CLKS_PER_BIT.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state.
  - 8N1 (or 8N2) frame that matches the existing receiver.

## Test plan
- Reset and idle: hold `rst_b` = 0 for 3 cycles, then release, no pushes → `uart_tx` = 1, `tx_ready` = 1, `tx_busy` = 0 and `fifo_level` = 0 for 1000 cycles.
- Single byte 0xA5 at defaults → line reads 0 | 1,0,1,0,0,1,0,1 | 1, each level held 40 cycles. `tx_done` is a single pulse at cycle 400 after the start edge.
- Burst of 16 bytes 0x00..0x0F:
  - `tx_ready` drops once 16 are queued.
  - A 17th push of 0xFF while full is dropped.
  - 16 frames go out back-to-back with no idle cycles, and 0xFF is never seen.
- Random 200 bytes pushed with random `tx_valid` gaps, decoded by a bench-model receiver → received stream matches the sent stream exactly, including across pointer wrap-around.
- Reset asserted mid-DATA of byte 0x3C with 5 bytes queued → `uart_tx` = 1 and `fifo_level` = 0 asynchronously. No `tx_done`, and the line stays idle after release.
- With `UART_TX_PARITY_EN`, bytes 0x07 and 0x03 → parity bits 1 and 0 respectively. Frame length is 440 cycles.
